// File: rtl/mult_arb_pkg.sv
// Shared constants and sizing helpers for the multiplier arbiter slice.
package mult_arb_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int NREQ_DEF  = 4;
  localparam int LAT_DEF   = 2;
  localparam int DEPTH_DEF = 4;

  // Ceiling log2 with a floor of 1 so a 1-entry structure still gets a 1-bit pointer
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Tag record {vld, id}
  function automatic int tag_w(input int idw);
    return 1 + idw;
  endfunction

  // FIFO entry {id, y}
  function automatic int entry_w(input int idw, input int width);
    return idw + 2 * width;
  endfunction
endpackage

// File: rtl/mult_arb_fifo.sv
// First-word-fall-through result FIFO with occupancy count; pointers wrap mod DEPTH.
module mult_arb_fifo
  import mult_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = 8,
  localparam int PW   = clog2(DEPTH),
  localparam int CW   = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic [CW-1:0] count
);
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rptr, wptr;
  logic          pop_ok;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid  = (count != '0);
  assign pop_ok = pop & valid;
  assign dout   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= nxt(wptr);
      if (pop_ok) rptr <= nxt(rptr);
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // The credit check upstream must make this unreachable
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && count == CW'(DEPTH)));
endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one fixed-latency multiplier with credit-checked FWFT result return.
// MULT_ARB_FIXED_PRIO_EN: lowest-index-wins arbitration instead of round-robin (no ptr).
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF,
  parameter int LAT   = LAT_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int IDW  = clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_y,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_y,
  output logic                  busy
);
  localparam int EW = entry_w(IDW, WIDTH);
  localparam int CW = clog2(DEPTH + 1);
  localparam int SW = clog2(LAT + DEPTH + 1) + 1;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  tag_t [LAT:1]  tag_pipe;
  logic [CW-1:0] fifo_cnt;
  logic [SW-1:0] inflight;
  logic          credit;
  logic          gnt_any;
  logic [IDW-1:0] gnt_id;
  logic [EW-1:0] fifo_dout;

  always_comb begin
    inflight = '0;
    for (int s = 1; s <= LAT; s++) inflight += SW'(tag_pipe[s].vld);
  end

  // Credit uses registered occupancy only, so a same-cycle pop frees nothing yet
  assign credit = !rst && ((inflight + SW'(fifo_cnt)) < SW'(DEPTH));

`ifdef MULT_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(k);
      end
    end
    if (!credit) begin
      gnt_any = 1'b0;
      gnt_id  = '0;
    end
  end
`else
  logic [IDW-1:0] ptr;

  // Scan backwards from ptr+NREQ-1 so the last hit is the first in rotation order
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx -= NREQ;
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
    if (!credit) begin
      gnt_any = 1'b0;
      gnt_id  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          ptr <= '0;
    else if (gnt_any) ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  end
`endif

  assign req_ready = gnt_any ? (NREQ'(1) << gnt_id) : '0;
  assign mul_a     = gnt_any ? req_a[gnt_id*WIDTH +: WIDTH] : '0;
  assign mul_b     = gnt_any ? req_b[gnt_id*WIDTH +: WIDTH] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[1] <= '{vld: gnt_any, id: gnt_id};
      for (int s = 2; s <= LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  mult_arb_fifo #(.DEPTH(DEPTH), .DW(EW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_pipe[LAT].vld),
    .din   ({tag_pipe[LAT].id, mul_y}),
    .pop   (rsp_ready),
    .dout  (fifo_dout),
    .valid (rsp_valid),
    .count (fifo_cnt)
  );

  assign rsp_id = fifo_dout[EW-1 -: IDW];
  assign rsp_y  = fifo_dout[2*WIDTH-1:0];
  assign busy   = (inflight != '0) || rsp_valid;
endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized + directed bench for mult_arbiter against a queue-based issue/return model.
module tb_mult_arbiter;
  localparam int W = 8, N = 4, LAT = 2, DEPTH = 4, IDW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic [W-1:0]     mul_a, mul_b, ma_q, mb_q;
  logic [2*W-1:0]   mul_y, rsp_y;
  logic             rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]   rsp_id;

  always #5 clk = ~clk;

  mult_arbiter #(.WIDTH(W), .NREQ(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_y(rsp_y), .busy(busy)
  );

  // Shared multiplier stand-in: input register then product register
  always_ff @(posedge clk) begin
    ma_q  <= mul_a;
    mb_q  <= mul_b;
    mul_y <= 16'(ma_q) * 16'(mb_q);
  end

  typedef struct {
    int id;
    int y;
    int rdy;
  } exp_t;

  exp_t q[$];
  int   ptr, outstanding, cyc;
  int   n_chk, n_fail;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack(input int x0, x1, x2, x3);
    return {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
  endfunction

  // One cycle: drive, check combinational/registered outputs mid-cycle, advance model after the edge
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] a, b,
                      input logic rr, input logic rs);
    int g, ea, eb;
    logic ev;
    rst = rs; req_valid = v; req_a = a; req_b = b; rsp_ready = rr;
    @(negedge clk);
    g = -1;
    if (!rs && outstanding < DEPTH) begin
      for (int k = 0; k < N; k++) begin
        int i;
`ifdef MULT_ARB_FIXED_PRIO_EN
        i = k;
`else
        i = (ptr + k) % N;
`endif
        if (v[i] && g < 0) g = i;
      end
    end
    ea = (g >= 0) ? int'(a[g*W +: W]) : 0;
    eb = (g >= 0) ? int'(b[g*W +: W]) : 0;
    chk("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
    chk("mul_a", mul_a, ea);
    chk("mul_b", mul_b, eb);
    ev = (q.size() > 0) && (q[0].rdy <= cyc);
    if (!rs) begin
      chk("rsp_valid", rsp_valid, ev);
      chk("busy", busy, outstanding != 0);
      if (ev) begin
        chk("rsp_id", rsp_id, q[0].id);
        chk("rsp_y", rsp_y, q[0].y);
      end
    end
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      ptr = 0;
      outstanding = 0;
    end else begin
      if (ev && rr) begin
        void'(q.pop_front());
        outstanding--;
      end
      if (g >= 0) begin
        q.push_back('{id: g, y: ea * eb, rdy: cyc + LAT + 1});
        outstanding++;
        ptr = (g + 1) % N;
      end
    end
    cyc++;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; ptr = 0; outstanding = 0;
    step('0, '0, '0, 1'b0, 1'b1);
    step('0, '0, '0, 1'b0, 1'b1);
    step('0, '0, '0, 1'b1, 1'b0);   // post-reset state: rsp_valid=0, busy=0

    // single request 3*5 from requester 0, then drain
    step(4'b0001, pack(3, 0, 0, 0), pack(5, 0, 0, 0), 1'b1, 1'b0);
    repeat (5) step('0, '0, '0, 1'b1, 1'b0);

    // all requesters continuously valid with a ready consumer
    repeat (12) step(4'b1111, pack(1, 2, 3, 4), pack(10, 20, 30, 40), 1'b1, 1'b0);
    repeat (6) step('0, '0, '0, 1'b1, 1'b0);

    // consumer stalled: credit limit, then release
    repeat (8) step(4'b1111, pack(5, 6, 7, 8), pack(9, 9, 9, 9), 1'b0, 1'b0);
    repeat (10) step(4'b1111, pack(5, 6, 7, 8), pack(9, 9, 9, 9), 1'b1, 1'b0);
    repeat (6) step('0, '0, '0, 1'b1, 1'b0);

    // operand extremes on requesters 1..3
    repeat (4) step(4'b1110, pack(0, 255, 0, 1), pack(0, 255, 200, 255), 1'b1, 1'b0);
    repeat (6) step('0, '0, '0, 1'b1, 1'b0);

    // reset one cycle after two issues discards them and rewinds ptr
    step(4'b0001, pack(7, 0, 0, 0), pack(7, 0, 0, 0), 1'b1, 1'b0);
    step(4'b0010, pack(0, 9, 0, 0), pack(0, 9, 0, 0), 1'b1, 1'b0);
    step('0, '0, '0, 1'b1, 1'b1);
    step(4'b1111, pack(2, 3, 4, 5), pack(2, 3, 4, 5), 1'b1, 1'b0);
    repeat (6) step('0, '0, '0, 1'b1, 1'b0);

    // requesters 0 and 3 contend continuously
    repeat (10) step(4'b1001, pack(11, 0, 0, 13), pack(17, 0, 0, 19), 1'b1, 1'b0);
    repeat (6) step('0, '0, '0, 1'b1, 1'b0);

    // randomized traffic with backpressure and occasional reset
    repeat (3000) begin
      step(N'($urandom), $urandom, $urandom, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 199) == 0));
    end
    repeat (8) step('0, '0, '0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
